// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and the MEM-stage load/store unit state type.
package riscv_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Store lane replication / byte enables, load extract and extend, misalign detect.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        mem_op,
    input  logic        store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic        size_b;
    logic        size_h;

    assign shifted = load_word >> {offset, 3'b000};

    // Unsigned sizes only exist for loads; a store with BU/HU encoding is a word store.
    assign size_b = (funct3 == FUNCT3_B) || ((funct3 == FUNCT3_BU) && !store);
    assign size_h = (funct3 == FUNCT3_H) || ((funct3 == FUNCT3_HU) && !store);

    always_comb begin
        wdata      = store_data;
        be         = 4'b1111;
        load_data  = load_word;
        misaligned = 1'b0;
        if (size_b) begin
            wdata     = {4{store_data[7:0]}};
            be        = 4'b0001 << offset;
            load_data = (funct3 == FUNCT3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'b0, shifted[7:0]};
        end else if (size_h) begin
            wdata      = {2{store_data[15:0]}};
            be         = 4'b0011 << offset;
            load_data  = (funct3 == FUNCT3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'b0, shifted[15:0]};
            misaligned = mem_op && offset[0];
        end else begin
            misaligned = mem_op && (offset != 2'b00);
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: req/gnt/rvalid bus sequencing, stall generation, timeout and MEM/WB register.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic [31:0] read_data,
    output logic [31:0] alu_result,
    output logic [4:0]  rd
);

    lsu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             mem_op;
    logic             is_load;
    logic             is_store;
    logic             misaligned;
    logic             access;
    logic             complete;
    logic             timeout;
    logic [31:0]      lane_wdata;
    logic [3:0]       lane_be;
    logic [31:0]      load_data;

    lsu_align u_align (
        .funct3     (funct3_in),
        .offset     (alu_result_in[1:0]),
        .mem_op     (mem_op),
        .store      (is_store),
        .store_data (rs2_data_in),
        .load_word  (dmem_rdata),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign mem_op   = MemRead_in | MemWrite_in;
    assign is_load  = MemRead_in;
    assign is_store = MemWrite_in & ~MemRead_in;
    assign access   = mem_op & ~misaligned;
    assign timeout  = (state != IDLE) && (cnt == CNT_W'(TIMEOUT));

    // A timeout outranks a gnt/rvalid arriving in the same cycle.
    always_comb begin
        complete = 1'b0;
        if (access && !timeout) begin
            case (state)
                IDLE, REQ: complete = is_store & dmem_gnt;
                WAIT:      complete = dmem_rvalid;
                default:   complete = 1'b0;
            endcase
        end
    end

    // Reset gates the combinational bus/stall outputs so they drop immediately.
    assign mem_stall  = ~reset & access & ~complete & ~timeout;
    assign dmem_req   = ~reset & access & ((state == IDLE) | (state == REQ));
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = dmem_req ? {alu_result_in[31:2], 2'b00} : 32'b0;
    assign dmem_wdata = dmem_we ? lane_wdata : 32'b0;
    assign dmem_be    = dmem_req ? lane_be : 4'b0;

    // The counter tracks stall cycles of the current access, including the first IDLE one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access && !(is_store && dmem_gnt)) begin
                        state <= dmem_gnt ? WAIT : REQ;
                        cnt   <= CNT_W'(1);
                    end
                end
                REQ: begin
                    if (timeout || (dmem_gnt && is_store)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        if (dmem_gnt) state <= WAIT;
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (timeout || dmem_rvalid) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Memory ops reach WB only on their completion edge; everything else is a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            MemtoReg   <= 1'b0;
            read_data  <= '0;
            alu_result <= '0;
            rd         <= '0;
            misalign   <= 1'b0;
        end else begin
            misalign <= (state == IDLE) & mem_op & misaligned;
            if (!mem_op || complete) begin
                RegWrite   <= RegWrite_in;
                MemtoReg   <= MemtoReg_in;
                read_data  <= (complete && is_load) ? load_data : 32'b0;
                alu_result <= alu_result_in;
                rd         <= rd_in;
            end else begin
                RegWrite   <= 1'b0;
                MemtoReg   <= 1'b0;
                read_data  <= '0;
                alu_result <= '0;
                rd         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu against a transaction-level model of the MEM stage.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in, rs2_data_in;
    logic [4:0]  rd_in;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        dmem_req, dmem_we, mem_stall, misalign, bus_err, RegWrite, MemtoReg;
    logic [31:0] dmem_addr, dmem_wdata, read_data, alu_result;
    logic [3:0]  dmem_be;
    logic [4:0]  rd;

    logic        to_dmem_req, to_dmem_we, to_mem_stall, to_misalign, to_bus_err, to_RegWrite, to_MemtoReg;
    logic [31:0] to_dmem_addr, to_dmem_wdata, to_read_data, to_alu_result;
    logic [3:0]  to_dmem_be;
    logic [4:0]  to_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .funct3_in(funct3_in), .alu_result_in(alu_result_in),
        .rs2_data_in(rs2_data_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .misalign(misalign), .bus_err(bus_err),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .read_data(read_data),
        .alu_result(alu_result), .rd(rd)
    );

    mem_stage_lsu #(.TIMEOUT(4), .CNT_W(8)) dut_to (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .funct3_in(funct3_in), .alu_result_in(alu_result_in),
        .rs2_data_in(rs2_data_in), .rd_in(rd_in),
        .dmem_req(to_dmem_req), .dmem_we(to_dmem_we), .dmem_addr(to_dmem_addr),
        .dmem_wdata(to_dmem_wdata), .dmem_be(to_dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(to_mem_stall), .misalign(to_misalign), .bus_err(to_bus_err),
        .RegWrite(to_RegWrite), .MemtoReg(to_MemtoReg), .read_data(to_read_data),
        .alu_result(to_alu_result), .rd(to_rd)
    );

    // Access size in bytes; unsigned encodings are word-sized for stores.
    function automatic int size_of(input logic [2:0] f3, input logic store);
        if (f3 == 3'b000 || (f3 == 3'b100 && !store)) return 1;
        if (f3 == 3'b001 || (f3 == 3'b101 && !store)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int          sz;
        int          off;
        logic [31:0] v;
        sz  = size_of(f3, 1'b0);
        off = int'(addr % 4);
        v   = word >> (8 * off);
        if (sz == 1) begin
            v = v % 256;
            if (f3 == 3'b000 && v >= 128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = v % 65536;
            if (f3 == 3'b001 && v >= 32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        int off;
        logic [3:0] b;
        sz  = size_of(f3, 1'b1);
        off = int'(addr % 4);
        b   = 4'b0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) b[i] = 1'b1;
        return (sz == 4) ? 4'hF : b;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
        int sz;
        sz = size_of(f3, 1'b1);
        if (sz == 1) return (data % 256) * 32'h0101_0101;
        if (sz == 2) return (data % 65536) * 32'h0001_0001;
        return data;
    endfunction

    task automatic apply_stimulus(input logic rd_en, input logic wr_en, input logic regw,
                                  input logic m2r, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [4:0] rdi);
        MemRead_in    = rd_en;
        MemWrite_in   = wr_en;
        RegWrite_in   = regw;
        MemtoReg_in   = m2r;
        funct3_in     = f3;
        alu_result_in = addr;
        rs2_data_in   = data;
        rd_in         = rdi;
    endtask

    task automatic pulse_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0, 5'b0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One EX/MEM instruction: gnt arrives dg cycles after presentation, rvalid dr cycles after gnt.
    task automatic do_op(input string name, input logic rd_en, input logic wr_en, input logic regw,
                         input logic m2r, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rdi, input logic [31:0] word,
                         input int dg, input int dr);
        logic mem_op, is_load, is_store, mis, access;
        int   sz, done_c;
        logic [31:0] exp_rd;
        mem_op   = rd_en | wr_en;
        is_load  = rd_en;
        is_store = wr_en & ~rd_en;
        sz       = size_of(f3, is_store);
        mis      = mem_op && ((sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0));
        access   = mem_op && !mis;
        done_c   = !access ? 0 : (is_store ? dg : dg + dr);
        apply_stimulus(rd_en, wr_en, regw, m2r, f3, addr, data, rdi);
        dmem_rdata = word;
        for (int c = 0; c <= done_c; c++) begin
            dmem_gnt    = access && (c == dg);
            dmem_rvalid = access && is_load && (c == dg + dr);
            @(negedge clk);
            checks++;
            if (mem_stall !== (c < done_c)) begin
                errors++;
                $display("[TB] FAIL %s stall c=%0d: got %b expected %b", name, c, mem_stall, c < done_c);
            end
            checks++;
            if (dmem_req !== (access && c <= dg)) begin
                errors++;
                $display("[TB] FAIL %s req c=%0d: got %b expected %b", name, c, dmem_req, access && c <= dg);
            end
            if (access && c == dg) begin
                checks++;
                if (dmem_addr !== (addr - addr % 4) || dmem_we !== is_store) begin
                    errors++;
                    $display("[TB] FAIL %s addr/we: got %h/%b expected %h/%b", name, dmem_addr, dmem_we,
                             addr - addr % 4, is_store);
                end
                if (is_store) begin
                    checks++;
                    if (dmem_be !== model_be(f3, addr) || dmem_wdata !== model_wdata(f3, data)) begin
                        errors++;
                        $display("[TB] FAIL %s be/wdata: got %b/%h expected %b/%h", name, dmem_be,
                                 dmem_wdata, model_be(f3, addr), model_wdata(f3, data));
                    end
                end
            end
            if (c > 0) begin
                checks++;
                if (RegWrite !== 1'b0 || rd !== 5'd0 || misalign !== 1'b0 || bus_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s bubble c=%0d: got RegWrite=%b rd=%0d misalign=%b bus_err=%b expected 0",
                             name, c, RegWrite, rd, misalign, bus_err);
                end
            end
            @(posedge clk);
            #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        checks++;
        if (mis) begin
            if (RegWrite !== 1'b0 || rd !== 5'd0 || misalign !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s misalign wb: got RegWrite=%b rd=%0d misalign=%b expected 0/0/1",
                         name, RegWrite, rd, misalign);
            end
        end else begin
            exp_rd = is_load ? model_load(f3, addr, word) : 32'b0;
            if (RegWrite !== regw || MemtoReg !== m2r || rd !== rdi || alu_result !== addr ||
                read_data !== exp_rd || misalign !== 1'b0 || bus_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s wb: got %b %b rd=%0d alu=%h data=%h mis=%b err=%b expected %b %b rd=%0d alu=%h data=%h 0 0",
                         name, RegWrite, MemtoReg, rd, alu_result, read_data, misalign, bus_err,
                         regw, m2r, rdi, addr, exp_rd);
            end
        end
    endtask

    task automatic test_reset();
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, FUNCT3_W, 32'h0000_0100, 32'h0, 5'd3);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        reset       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, misalign, bus_err,
             RegWrite, MemtoReg, read_data, alu_result, rd} !== '0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got stall=%b req=%b RegWrite=%b rd=%0d expected all 0",
                     mem_stall, dmem_req, RegWrite, rd);
        end
        checks++;
        if ({to_mem_stall, to_dmem_req, to_bus_err, to_RegWrite, to_rd} !== '0) begin
            errors++;
            $display("[TB] FAIL reset outputs timeout dut: got stall=%b req=%b expected 0",
                     to_mem_stall, to_dmem_req);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0, 5'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_word();
        do_op("sw", 1'b0, 1'b1, 1'b0, 1'b0, FUNCT3_W, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,
              32'h0, 0, 1);
    endtask

    task automatic test_load_byte();
        do_op("lb", 1'b1, 1'b0, 1'b1, 1'b1, FUNCT3_B, 32'h0000_0103, 32'h0, 5'd5,
              32'h80FF_0000, 0, 1);
    endtask

    task automatic test_load_half_delayed();
        do_op("lhu", 1'b1, 1'b0, 1'b1, 1'b1, FUNCT3_HU, 32'h0000_0102, 32'h0, 5'd6,
              32'h80FF_0000, 3, 2);
    endtask

    task automatic test_misalign();
        do_op("lw_mis", 1'b1, 1'b0, 1'b1, 1'b1, FUNCT3_W, 32'h0000_0101, 32'h0, 5'd8,
              32'h1234_5678, 0, 1);
        do_op("sh_mis", 1'b0, 1'b1, 1'b0, 1'b0, FUNCT3_H, 32'h0000_0203, 32'hAAAA_5555, 5'd0,
              32'h0, 0, 1);
        do_op("after_mis", 1'b0, 1'b0, 1'b1, 1'b0, 3'b0, 32'h0000_0042, 32'h0, 5'd9, 32'h0, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_op("b2b_sb", 1'b0, 1'b1, 1'b0, 1'b0, FUNCT3_B, 32'h0000_0300 + i, 32'h0000_00A0 + i,
                  5'd0, 32'h0, 0, 1);
            do_op("b2b_alu", 1'b0, 1'b0, 1'b1, 1'b0, 3'b0, 32'h1111_0000 + i, 32'h0, 5'(10 + i),
                  32'h0, 0, 1);
            do_op("b2b_lh", 1'b1, 1'b0, 1'b1, 1'b1, FUNCT3_H, 32'h0000_0400 + 2 * i, 32'h0, 5'(20 + i),
                  32'h8001_7FFE + i, 0, 1);
        end
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [2:0] f3;
            kind = $urandom_range(0, 2);
            f3   = (kind == 1) ? ld_f3[$urandom_range(0, 6)] : 3'($urandom_range(0, 2));
            do_op("rand", kind == 1, kind == 2, 1'($urandom), 1'($urandom), f3, $urandom(),
                  $urandom(), 5'($urandom), $urandom(), $urandom_range(0, 4), $urandom_range(1, 3));
        end
    endtask

    task automatic test_timeout();
        int stalls;
        bit dropped;
        pulse_reset();
        stalls  = 0;
        dropped = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, FUNCT3_W, 32'h0000_0200, 32'h0, 5'd7);
        for (int c = 0; c < 12 && !dropped; c++) begin
            @(negedge clk);
            if (to_mem_stall) stalls++;
            else dropped = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!dropped || stalls != 4) begin
            errors++;
            $display("[TB] FAIL timeout stalls: got %0d (dropped=%b) expected 4", stalls, dropped);
        end
        checks++;
        if (to_bus_err !== 1'b1 || to_RegWrite !== 1'b0 || to_rd !== 5'd0) begin
            errors++;
            $display("[TB] FAIL timeout bus_err: got err=%b RegWrite=%b rd=%0d expected 1/0/0",
                     to_bus_err, to_RegWrite, to_rd);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0, 5'b0);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (to_mem_stall !== 1'b0 || to_dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout idle: got stall=%b req=%b expected 0/0", to_mem_stall, to_dmem_req);
        end
        @(posedge clk);
        #1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        checks++;
        if (to_bus_err !== 1'b0 || to_RegWrite !== 1'b0 || to_read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL timeout late resp: got err=%b RegWrite=%b data=%h expected 0/0/0",
                     to_bus_err, to_RegWrite, to_read_data);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_wait();
        pulse_reset();
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, FUNCT3_B, 32'h0000_0104, 32'h0, 5'd9);
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait state: got stall=%b req=%b expected 1/0", mem_stall, dmem_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_stall, dmem_req, dmem_we, dmem_be, misalign, bus_err, RegWrite, MemtoReg,
             read_data, alu_result, rd} !== '0) begin
            errors++;
            $display("[TB] FAIL reset mid wait: got stall=%b req=%b RegWrite=%b expected all 0",
                     mem_stall, dmem_req, RegWrite);
        end
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0, 5'b0);
        reset       = 1'b0;
        dmem_rdata  = 32'h8765_4321;
        dmem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        checks++;
        if (RegWrite !== 1'b0 || read_data !== 32'h0 || rd !== 5'd0 || mem_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late rvalid after reset: got RegWrite=%b data=%h rd=%0d stall=%b expected 0",
                     RegWrite, read_data, rd, mem_stall);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half_delayed();
        test_misalign();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
